branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of direct-mapped BTB entries (power of two, 4..64).
REQ-002 SHALL have ports CLK  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port RESET  input  1  reset; reset is synchronous and active-high.
REQ-004 SHALL have ports PCF  input  32  fetch PC; PredictTakenF  output  1  taken prediction; PredictedPCF  output  32  next PC to fetch.
REQ-005 SHALL have ports StallF, StallD, FlushD, StallE, FlushE  input  1 each  hazard-unit pipeline controls.
REQ-006 SHALL have ports PCE  input  32  E-stage PC; BranchE  input  1  E instruction is a branch; PCSrcE  input  1  branch actually taken; BranchTargetE  input  32  resolved target.
REQ-007 SHALL have ports Mispredicted  output  1  E-stage misprediction to hazard unit; RedirectPC  output  32  corrected fetch PC.

Function
REQ-008 SHALL index BTB with PCF[log2(ENTRIES)+1:2]; tag = remaining PC[31:log2(ENTRIES)+2]; entry = valid, tag, target[31:0], 2-bit counter.
REQ-009 SHALL compute lookup combinationally: hit = valid & tag match; PredictTakenF = hit & counter[1]; PredictedPCF = target if PredictTakenF else PCF+4.
REQ-010 SHALL carry {PredictTaken, PredictedPC} through an F/D register (load when ~StallD) and a D/E register (load when ~StallE).
REQ-011 SHALL clear a pipeline register (PredictTaken=0) when its flush is asserted; flush takes priority over stall in the same cycle.
REQ-012 SHALL assert Mispredicted combinationally when BranchE & (PredTakenE != PCSrcE, or both taken and PredictedPCE != BranchTargetE).
REQ-013 SHALL assert Mispredicted when ~BranchE & PredTakenE (aliased hit on non-branch).
REQ-014 SHALL drive RedirectPC = BranchTargetE if BranchE & PCSrcE, else PCE+4.
REQ-015 SHALL force Mispredicted=0 while StallE=1.
REQ-016 SHALL update BTB on the rising edge only when BranchE & ~StallE & ~RESET; exactly one update per resolved branch.
REQ-017 SHALL on taken branch: write valid=1, tag, target=BranchTargetE; counter increments saturating at 2'b11, or is set to 2'b10 on miss/tag mismatch (allocation).
REQ-018 SHALL on not-taken branch: decrement counter saturating at 2'b00 if hit; no allocation on miss.
REQ-019 SHALL return pre-update contents when lookup and update hit the same index in one cycle (write-then-read next cycle).

Reset
REQ-020 SHALL on RESET clear all valid bits, set counters to 2'b01, clear both pipeline registers.
REQ-021 SHALL output PredictTakenF=0, PredictedPCF=PCF+4, Mispredicted=0 in the cycle after RESET; RESET mid-update discards the update.

Configuration
REQ-022 SHALL, with BP_COUNTER_EN defined, use 2-bit counters per REQ-009/017/018.
REQ-023 SHALL, without BP_COUNTER_EN, omit counters: PredictTakenF = hit; not-taken hit invalidates the entry.

Structure
REQ-024 SHALL place counter state constants (SNT=00, WNT=01, WT=10, ST=11) and default ENTRIES in shared package bp_pkg.
REQ-025 SHALL contain one sub-module btb_array (storage, read port, write port, reset clear).

Verification
REQ-026 SHALL cover: reset, PCF=0x100 -> PredictTakenF=0, PredictedPCF=0x104.
REQ-027 SHALL cover: taken branch PCE=0x100 target 0x200 resolved -> next lookup PCF=0x100 gives PredictTakenF=1, PredictedPCF=0x200 (counter 10).
REQ-028 SHALL cover: same branch not-taken twice -> counter 10->01->00, PredictTakenF=0; first not-taken cycle Mispredicted=1, RedirectPC=0x104.
REQ-029 SHALL cover: predicted-taken entry then FlushD asserted with StallD=1 same cycle -> D register cleared, no Mispredicted at E.
REQ-030 SHALL cover: StallE=1 for 4 cycles with branch in E -> Mispredicted=0, no BTB change until StallE falls, then one update.
REQ-031 SHALL cover: PCF=0x140 (alias of 0x100, ENTRIES=16) -> no hit; non-branch with forced PredTakenE=1 -> Mispredicted=1, RedirectPC=PCE+4.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared constants and types for the BTB-based branch predictor (package bp_pkg).
package bp_pkg;

  localparam int DEFAULT_ENTRIES = 16;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } counterState;

  typedef struct packed {
    logic        taken;
    logic [31:0] pc;
  } predInfo;

  function automatic counterState satInc(input counterState c);
    return (c == ST) ? ST : counterState'(c + 2'b01);
  endfunction

  function automatic counterState satDec(input counterState c);
    return (c == SNT) ? SNT : counterState'(c - 2'b01);
  endfunction

endpackage

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB storage: fetch read port, resolve-side read port, one write port.
// Counter storage exists only when BP_COUNTER_EN is defined.
module btb_array
  import bp_pkg::*;
#(
  parameter int ENTRIES = DEFAULT_ENTRIES,
  parameter int TAG_W   = 26
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [$clog2(ENTRIES)-1:0] rdIdxA,
  output logic                       rdValidA,
  output logic [TAG_W-1:0]           rdTagA,
  output logic [31:0]                rdTargetA,
  input  logic [$clog2(ENTRIES)-1:0] rdIdxB,
  output logic                       rdValidB,
  output logic [TAG_W-1:0]           rdTagB,
`ifdef BP_COUNTER_EN
  output counterState                rdCtrA,
  output counterState                rdCtrB,
  input  counterState                wrCtr,
`endif
  input  logic                       wrEn,
  input  logic [$clog2(ENTRIES)-1:0] wrIdx,
  input  logic                       wrValid,
  input  logic [TAG_W-1:0]           wrTag,
  input  logic [31:0]                wrTarget
);

  logic             validMem  [ENTRIES];
  logic [TAG_W-1:0] tagMem    [ENTRIES];
  logic [31:0]      targetMem [ENTRIES];

  // Reads come straight from the registers, so a same-cycle write is seen next cycle.
  assign rdValidA  = validMem[rdIdxA];
  assign rdTagA    = tagMem[rdIdxA];
  assign rdTargetA = targetMem[rdIdxA];
  assign rdValidB  = validMem[rdIdxB];
  assign rdTagB    = tagMem[rdIdxB];

`ifdef BP_COUNTER_EN
  counterState ctrMem [ENTRIES];

  assign rdCtrA = ctrMem[rdIdxA];
  assign rdCtrB = ctrMem[rdIdxB];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) ctrMem[i] <= WNT;
    end else if (wrEn) begin
      ctrMem[wrIdx] <= wrCtr;
    end
  end
`endif

  // Reset wins over a pending write, so an update racing reset is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) validMem[i] <= 1'b0;
    end else if (wrEn) begin
      validMem[wrIdx]  <= wrValid;
      tagMem[wrIdx]    <= wrTag;
      targetMem[wrIdx] <= wrTarget;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage BTB predictor with F/D and D/E prediction tracking and E-stage misprediction check.
// Optional BP_COUNTER_EN adds 2-bit saturating counters; otherwise a hit means predict taken.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = DEFAULT_ENTRIES
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] PCF,
  output logic        PredictTakenF,
  output logic [31:0] PredictedPCF,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        StallE,
  input  logic        FlushE,
  input  logic [31:0] PCE,
  input  logic        BranchE,
  input  logic        PCSrcE,
  input  logic [31:0] BranchTargetE,
  output logic        Mispredicted,
  output logic [31:0] RedirectPC
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [IDX_W-1:0] fetchIdx, updIdx;
  logic [TAG_W-1:0] fetchTag, updTag, fetchTagRd, updTagRd;
  logic             fetchValid, updValid, fetchHit, updHit;
  logic [31:0]      fetchTarget;
  logic             wrEn, wrValid;
  predInfo          predF, predD, predE;
  logic             unusedSignals;

  // Fetch keeps its own stall; the predictor has no state owned by the F stage.
  assign unusedSignals = StallF;

  assign fetchIdx = PCF[IDX_W+1:2];
  assign fetchTag = PCF[31:IDX_W+2];
  assign updIdx   = PCE[IDX_W+1:2];
  assign updTag   = PCE[31:IDX_W+2];
  assign fetchHit = fetchValid & (fetchTagRd == fetchTag);
  assign updHit   = updValid & (updTagRd == updTag);

`ifdef BP_COUNTER_EN
  counterState fetchCtr, updCtr, wrCtr;

  assign PredictTakenF = fetchHit & fetchCtr[1];
  assign wrValid       = 1'b1;

  // Taken: strengthen a hit, allocate weakly-taken on a miss. Not taken: weaken.
  always_comb begin
    wrCtr = WT;
    if (PCSrcE) wrCtr = updHit ? satInc(updCtr) : WT;
    else        wrCtr = satDec(updCtr);
  end
`else
  assign PredictTakenF = fetchHit;
  assign wrValid       = PCSrcE;
`endif

  assign PredictedPCF = PredictTakenF ? fetchTarget : PCF + 32'd4;
  assign wrEn         = BranchE & ~StallE & (PCSrcE | updHit);
  assign predF        = '{taken: PredictTakenF, pc: PredictedPCF};

  btb_array #(
    .ENTRIES(ENTRIES),
    .TAG_W  (TAG_W)
  ) btb (
    .clock    (CLK),
    .reset    (RESET),
    .rdIdxA   (fetchIdx),
    .rdValidA (fetchValid),
    .rdTagA   (fetchTagRd),
    .rdTargetA(fetchTarget),
    .rdIdxB   (updIdx),
    .rdValidB (updValid),
    .rdTagB   (updTagRd),
`ifdef BP_COUNTER_EN
    .rdCtrA   (fetchCtr),
    .rdCtrB   (updCtr),
    .wrCtr    (wrCtr),
`endif
    .wrEn     (wrEn),
    .wrIdx    (updIdx),
    .wrValid  (wrValid),
    .wrTag    (updTag),
    .wrTarget (BranchTargetE)
  );

  // Flush beats stall: a flushed stage never holds a stale taken prediction.
  always_ff @(posedge CLK) begin
    if (RESET || FlushD) predD <= '0;
    else if (!StallD)    predD <= predF;
  end

  always_ff @(posedge CLK) begin
    if (RESET || FlushE) predE <= '0;
    else if (!StallE)    predE <= predD;
  end

  // A taken prediction on a non-branch is an alias hit and must also be undone.
  always_comb begin
    Mispredicted = 1'b0;
    if (BranchE)
      Mispredicted = (predE.taken != PCSrcE) |
                     (predE.taken & PCSrcE & (predE.pc != BranchTargetE));
    else
      Mispredicted = predE.taken;
    if (StallE) Mispredicted = 1'b0;
  end

  assign RedirectPC = (BranchE & PCSrcE) ? BranchTargetE : PCE + 32'd4;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (ENTRIES=16); expectations follow BP_COUNTER_EN when defined.
module tb_branch_predictor;

`ifdef BP_COUNTER_EN
  localparam bit CtrEn = 1'b1;
`else
  localparam bit CtrEn = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] PCF;
  logic        PredictTakenF;
  logic [31:0] PredictedPCF;
  logic        StallF, StallD, FlushD, StallE, FlushE;
  logic [31:0] PCE;
  logic        BranchE, PCSrcE;
  logic [31:0] BranchTargetE;
  logic        Mispredicted;
  logic [31:0] RedirectPC;

  int vectorCount = 0;
  int missCount   = 0;

  branch_predictor #(.ENTRIES(16)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PCF          (PCF),
    .PredictTakenF(PredictTakenF),
    .PredictedPCF (PredictedPCF),
    .StallF       (StallF),
    .StallD       (StallD),
    .FlushD       (FlushD),
    .StallE       (StallE),
    .FlushE       (FlushE),
    .PCE          (PCE),
    .BranchE      (BranchE),
    .PCSrcE       (PCSrcE),
    .BranchTargetE(BranchTargetE),
    .Mispredicted (Mispredicted),
    .RedirectPC   (RedirectPC)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] pcf, input logic branch, input logic pcSrc,
                               input logic [31:0] pce, input logic [31:0] target);
    PCF           = pcf;
    BranchE       = branch;
    PCSrcE        = pcSrc;
    PCE           = pce;
    BranchTargetE = target;
    #1;
  endtask

  task automatic checkFetch(input string tag, input logic expTaken, input logic [31:0] expPc);
    checkOutput({tag, ".taken"}, {31'd0, PredictTakenF}, {31'd0, expTaken});
    checkOutput({tag, ".pc"}, PredictedPCF, expPc);
  endtask

  initial begin
    RESET = 1'b1;
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; StallE = 1'b0; FlushE = 1'b0;
    applyStimulus(32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    RESET = 1'b0;

    // Reset state
    applyStimulus(32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
    checkFetch("reset", 1'b0, 32'h104);
    checkOutput("reset.mis", {31'd0, Mispredicted}, 32'd0);

    // First taken resolve: predicted not-taken, lookup same index sees old contents
    applyStimulus(32'h100, 1'b1, 1'b1, 32'h100, 32'h200);
    checkOutput("alloc.mis", {31'd0, Mispredicted}, 32'd1);
    checkOutput("alloc.redirect", RedirectPC, 32'h200);
    checkFetch("alloc.sameCycle", 1'b0, 32'h104);
    tick();
    applyStimulus(32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
    checkFetch("hit", 1'b1, 32'h200);
    applyStimulus(32'h140, 1'b0, 1'b0, 32'h0, 32'h0);
    checkFetch("alias", 1'b0, 32'h144);

    // Flush with stall on D clears the taken prediction before it reaches E
    applyStimulus(32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    FlushD = 1'b1; StallD = 1'b1; StallE = 1'b1;
    tick();
    FlushD = 1'b0; StallD = 1'b0; StallE = 1'b0;
    applyStimulus(32'h300, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("flushD.mis", {31'd0, Mispredicted}, 32'd0);

    // Push a taken prediction for 0x100 into E
    applyStimulus(32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    applyStimulus(32'h300, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    applyStimulus(32'h300, 1'b0, 1'b0, 32'h180, 32'h0);
    checkOutput("nonBranch.mis", {31'd0, Mispredicted}, 32'd1);
    checkOutput("nonBranch.redirect", RedirectPC, 32'h184);
    StallE = 1'b1;
    #1;
    checkOutput("stallE.mis", {31'd0, Mispredicted}, 32'd0);
    StallE = 1'b0;
    applyStimulus(32'h100, 1'b1, 1'b1, 32'h100, 32'h200);
    checkOutput("correct.mis", {31'd0, Mispredicted}, 32'd0);
    applyStimulus(32'h100, 1'b1, 1'b1, 32'h100, 32'h280);
    checkOutput("wrongTarget.mis", {31'd0, Mispredicted}, 32'd1);
    applyStimulus(32'h100, 1'b1, 1'b0, 32'h100, 32'h200);
    checkOutput("notTaken.mis", {31'd0, Mispredicted}, 32'd1);
    checkOutput("notTaken.redirect", RedirectPC, 32'h104);

    // Held in E for four cycles: no mispredict, no BTB change
    StallE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput($sformatf("stall%0d.mis", i), {31'd0, Mispredicted}, 32'd0);
      checkOutput($sformatf("stall%0d.taken", i), {31'd0, PredictTakenF}, 32'd1);
      tick();
    end
    StallE = 1'b0;
    #1;
    checkOutput("release.mis", {31'd0, Mispredicted}, 32'd1);
    tick();
    applyStimulus(32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
    checkFetch("afterNotTaken1", 1'b0, 32'h104);

    // Second not-taken, prediction in E is not-taken
    applyStimulus(32'h300, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    applyStimulus(32'h300, 1'b1, 1'b0, 32'h100, 32'h200);
    checkOutput("notTaken2.mis", {31'd0, Mispredicted}, 32'd0);
    tick();
    applyStimulus(32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
    checkFetch("afterNotTaken2", 1'b0, 32'h104);

    // Climb back up: counter 00->01->10->11 (or plain reallocation)
    applyStimulus(32'h300, 1'b1, 1'b1, 32'h100, 32'h200);
    tick();
    applyStimulus(32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
    checkFetch("retake1", !CtrEn, CtrEn ? 32'h104 : 32'h200);
    applyStimulus(32'h300, 1'b1, 1'b1, 32'h100, 32'h200);
    tick();
    applyStimulus(32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
    checkFetch("retake2", 1'b1, 32'h200);
    applyStimulus(32'h300, 1'b1, 1'b1, 32'h100, 32'h240);
    tick();
    applyStimulus(32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
    checkFetch("retake3", 1'b1, 32'h240);
    applyStimulus(32'h300, 1'b1, 1'b0, 32'h100, 32'h0);
    tick();
    applyStimulus(32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
    checkFetch("strongNotTaken", CtrEn, CtrEn ? 32'h240 : 32'h104);

    // Aliased PC replaces the entry on a taken resolve
    applyStimulus(32'h300, 1'b1, 1'b1, 32'h140, 32'h400);
    tick();
    applyStimulus(32'h140, 1'b0, 1'b0, 32'h0, 32'h0);
    checkFetch("aliasAlloc", 1'b1, 32'h400);
    applyStimulus(32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
    checkFetch("aliasEvict", 1'b0, 32'h104);

    // Reset coinciding with an update drops the update and clears the table
    applyStimulus(32'h300, 1'b1, 1'b1, 32'h108, 32'h500);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    applyStimulus(32'h108, 1'b0, 1'b0, 32'h0, 32'h0);
    checkFetch("resetUpdate", 1'b0, 32'h10C);
    checkOutput("resetUpdate.mis", {31'd0, Mispredicted}, 32'd0);
    applyStimulus(32'h140, 1'b0, 1'b0, 32'h0, 32'h0);
    checkFetch("resetClear", 1'b0, 32'h144);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
